imm_ext_arbiter: RTL and testbench
==================================

IMM_EXT_ARBITER -- requirements
Module: imm_ext_arbiter

Interface
REQ-001 SHALL provide parameter: NBITS, default 32, result width (values below 32 unsupported).
REQ-002 SHALL have port: i_clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: i_rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port: i_req0_valid  in  1  decode-stage request valid.
REQ-005 SHALL have port: i_req0_imm  in  16  decode-stage immediate.
REQ-006 SHALL have port: i_req0_mode  in  2  decode-stage extension mode.
REQ-007 SHALL have port: o_req0_ready  out  1  decode-stage request accepted this cycle when high with valid.
REQ-008 SHALL have ports: i_req1_valid / i_req1_imm / i_req1_mode / o_req1_ready, same widths and meaning, for the debug unit.
REQ-009 SHALL have port: o_valid  out  1  result register holds unconsumed result.
REQ-010 SHALL have port: o_result  out  NBITS  extended immediate.
REQ-011 SHALL have port: o_grant_id  out  1  requester that produced o_result.
REQ-012 SHALL have port: i_ready  in  1  consumer accepts o_result when high with o_valid.

Function
REQ-013 SHALL implement a two-state output FSM: EMPTY (o_valid=0), FULL (o_valid=1).
REQ-014 SHALL define slot_free = (state==EMPTY) | i_ready.
REQ-015 SHALL assert o_reqN_ready only for the granted requester, and only when slot_free.
REQ-016 Arbitration: one valid requester -> grant it; both valid -> grant requester != last_served; none -> no grant.
REQ-017 SHALL keep the last_served register; update to N only on accept from N (validN & o_reqN_ready).
REQ-018 Accept -> next cycle: FULL, o_result = ext(imm, mode), o_grant_id = N; latency exactly 1 cycle.
REQ-019 Mode 00 -> imm sign-extended to NBITS.
REQ-020 Mode 01 -> imm zero-extended to NBITS.
REQ-021 Mode 10 -> imm in bits [31:16], bits [15:0] zero, bits above 31 zero.
REQ-022 Mode 11 -> all-zero result.
REQ-023 FULL & i_ready & no accept -> EMPTY; o_result/o_grant_id keep last value.
REQ-024 FULL & i_ready & accept same cycle -> stay FULL with new result (throughput 1 per cycle, no bubble).
REQ-025 FULL & ~i_ready -> o_result, o_grant_id, o_valid stable; both readies 0.
REQ-026 Requester inputs SHALL be sampled only on accept; changes while not ready are ignored.
REQ-027 Both valids high continuously with i_ready=1 -> strict alternation 0,1,0,1...; neither starves.

Reset
REQ-028 While i_rst high at a clock edge: state EMPTY, o_valid=0, o_result=0, o_grant_id=0, last_served=1 (requester 0 wins first tie).
REQ-029 o_req0_ready and o_req1_ready SHALL be 0 in every cycle i_rst is high; no accept occurs.
REQ-030 Reset mid-operation (FULL, pending result) SHALL discard the result without a consumer handshake.

Verification
REQ-031 Reset: i_rst high 2 cycles with both valids high -> o_valid=0, o_result=0, readies 0; first cycle after release grants requester 0.
REQ-032 Sign: req0 imm=0x8001 mode=00, i_ready=1 -> next cycle o_valid=1, o_result=0xFFFF8001, o_grant_id=0.
REQ-033 Alternation: both valid, req0 imm=0x0005 mode=00, req1 imm=0x1234 mode=10, i_ready=1 -> results 0x00000005, 0x12340000, 0x00000005... with grant ids 0,1,0.
REQ-034 Backpressure: FULL, i_ready=0 for 3 cycles -> o_result stable, both readies 0; i_ready=1 with req1 valid -> accepted same cycle, new result next cycle, no EMPTY gap.
REQ-035 Modes: imm=0x8001 mode=01 -> 0x00008001; imm=0xFFFF mode=11 -> 0x00000000.
REQ-036 Reset mid-op: FULL, i_ready=0, assert i_rst 1 cycle -> next cycle o_valid=0, o_result=0; next tie grants requester 0.

Source files
------------

// File: rtl/imm_ext_arbiter.sv
// Two-requester immediate-extension arbiter with a single-entry result register.
// Decode stage (req0) and debug unit (req1) compete for the extender; ties
// alternate with the requester that was not served last, so neither starves.
// The result slot refills in the same cycle it drains, sustaining one result
// per cycle.
//
// state | meaning
// ------+--------------------------------------------------
// EMPTY | no pending result, o_valid low, slot free
// FULL  | o_result holds an unconsumed result, o_valid high
module imm_ext_arbiter #(
    parameter int NBITS = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_req0_valid,
    input  logic [15:0]      i_req0_imm,
    input  logic [1:0]       i_req0_mode,
    output logic             o_req0_ready,
    input  logic             i_req1_valid,
    input  logic [15:0]      i_req1_imm,
    input  logic [1:0]       i_req1_mode,
    output logic             o_req1_ready,
    output logic             o_valid,
    output logic [NBITS-1:0] o_result,
    output logic             o_grant_id,
    input  logic             i_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state_q;
    logic              last_served_q;
    logic [NBITS-1:0]  result_q;
    logic              grant_id_q;

    logic              slot_free;
    logic              grant_any;
    logic              grant_sel;
    logic              accept;
    logic [15:0]       sel_imm;
    logic [1:0]        sel_mode;

    // Mode 10 places the immediate in bits [31:16] regardless of NBITS;
    // anything above bit 31 stays zero.
    function automatic logic [NBITS-1:0] ext(input logic [15:0] imm,
                                             input logic [1:0]  mode);
        logic [NBITS-1:0] r;
        r = '0;
        case (mode)
            2'b00:   r = {{(NBITS-16){imm[15]}}, imm};
            2'b01:   r[15:0] = imm;
            2'b10:   r[31:16] = imm;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Arbitration: single requester wins outright, a tie goes to whoever was not served last.
    always_comb begin
        slot_free = (state_q == EMPTY) | i_ready;
        grant_any = i_req0_valid | i_req1_valid;
        if (i_req0_valid && i_req1_valid) begin
            grant_sel = ~last_served_q;
        end else begin
            grant_sel = i_req1_valid;
        end
        // Readies are held low during reset so no request can slip in.
        accept       = grant_any & slot_free & ~i_rst;
        o_req0_ready = accept & ~grant_sel;
        o_req1_ready = accept & grant_sel;
        sel_imm      = grant_sel ? i_req1_imm  : i_req0_imm;
        sel_mode     = grant_sel ? i_req1_mode : i_req0_mode;
    end

    // Output FSM: load on accept, drain to EMPTY when consumed with nothing new.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= EMPTY;
            result_q      <= '0;
            grant_id_q    <= 1'b0;
            last_served_q <= 1'b1;
        end else if (accept) begin
            state_q       <= FULL;
            result_q      <= ext(sel_imm, sel_mode);
            grant_id_q    <= grant_sel;
            last_served_q <= grant_sel;
        end else if ((state_q == FULL) && i_ready) begin
            state_q       <= EMPTY;
        end
    end

    assign o_valid    = (state_q == FULL);
    assign o_result   = result_q;
    assign o_grant_id = grant_id_q;

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Directed bench for imm_ext_arbiter: reset, extension modes, tie alternation,
// backpressure hold and mid-operation reset, with hand-computed expectations.
module tb_imm_ext_arbiter;

    localparam int NBITS = 32;

    logic             i_clk;
    logic             i_rst;
    logic             i_req0_valid;
    logic [15:0]      i_req0_imm;
    logic [1:0]       i_req0_mode;
    logic             o_req0_ready;
    logic             i_req1_valid;
    logic [15:0]      i_req1_imm;
    logic [1:0]       i_req1_mode;
    logic             o_req1_ready;
    logic             o_valid;
    logic [NBITS-1:0] o_result;
    logic             o_grant_id;
    logic             i_ready;

    int checks;
    int failures;

    imm_ext_arbiter #(.NBITS(NBITS)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_req0_valid (i_req0_valid),
        .i_req0_imm   (i_req0_imm),
        .i_req0_mode  (i_req0_mode),
        .o_req0_ready (o_req0_ready),
        .i_req1_valid (i_req1_valid),
        .i_req1_imm   (i_req1_imm),
        .i_req1_mode  (i_req1_mode),
        .o_req1_ready (o_req1_ready),
        .o_valid      (o_valid),
        .o_result     (o_result),
        .o_grant_id   (o_grant_id),
        .i_ready      (i_ready)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] r, input logic g);
        chk({tag, ".valid"}, 64'(o_valid), 64'(v));
        chk({tag, ".result"}, 64'(o_result), 64'(r));
        chk({tag, ".gid"}, 64'(o_grant_id), 64'(g));
    endtask

    task automatic chk_rdy(input string tag, input logic r0, input logic r1);
        chk({tag, ".rdy0"}, 64'(o_req0_ready), 64'(r0));
        chk({tag, ".rdy1"}, 64'(o_req1_ready), 64'(r1));
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // reset with both requesters active
        i_rst        = 1'b1;
        i_ready      = 1'b1;
        i_req0_valid = 1'b1;
        i_req0_imm   = 16'h8001;
        i_req0_mode  = 2'b00;
        i_req1_valid = 1'b1;
        i_req1_imm   = 16'h1234;
        i_req1_mode  = 2'b10;
        #1;
        chk_rdy("rst_in", 1'b0, 1'b0);
        cyc();
        chk_rdy("rst_c1", 1'b0, 1'b0);
        cyc();
        chk_out("rst", 1'b0, 32'h0, 1'b0);
        chk_rdy("rst_c2", 1'b0, 1'b0);

        // first tie after reset goes to requester 0; sign extension
        i_rst = 1'b0;
        #1;
        chk_rdy("first_tie", 1'b1, 1'b0);
        cyc();
        chk_out("sign", 1'b1, 32'hFFFF_8001, 1'b0);

        // alternation at full throughput
        i_req0_imm = 16'h0005;
        #1;
        chk_rdy("alt_r1", 1'b0, 1'b1);
        cyc();
        chk_out("alt1", 1'b1, 32'h1234_0000, 1'b1);
        cyc();
        chk_out("alt2", 1'b1, 32'h0000_0005, 1'b0);
        cyc();
        chk_out("alt3", 1'b1, 32'h1234_0000, 1'b1);
        cyc();
        chk_out("alt4", 1'b1, 32'h0000_0005, 1'b0);

        // backpressure: hold for 3 cycles, req1 inputs wiggle and must be ignored
        i_ready      = 1'b0;
        i_req0_valid = 1'b0;
        i_req1_imm   = 16'h1111;
        i_req1_mode  = 2'b01;
        #1;
        chk_rdy("bp_in", 1'b0, 1'b0);
        cyc();
        chk_out("bp1", 1'b1, 32'h0000_0005, 1'b0);
        i_req1_imm = 16'h2222;
        #1;
        chk_rdy("bp1", 1'b0, 1'b0);
        cyc();
        chk_out("bp2", 1'b1, 32'h0000_0005, 1'b0);
        i_req1_imm = 16'h3333;
        #1;
        chk_rdy("bp2", 1'b0, 1'b0);
        cyc();
        chk_out("bp3", 1'b1, 32'h0000_0005, 1'b0);
        i_req1_imm = 16'hABCD;
        i_ready    = 1'b1;
        #1;
        chk_rdy("bp_rel", 1'b0, 1'b1);
        cyc();
        chk_out("bp_new", 1'b1, 32'h0000_ABCD, 1'b1);

        // zero extension, then drain to EMPTY holding the last result
        i_req1_valid = 1'b0;
        i_req0_valid = 1'b1;
        i_req0_imm   = 16'h8001;
        i_req0_mode  = 2'b01;
        #1;
        chk_rdy("zx_in", 1'b1, 1'b0);
        cyc();
        chk_out("zext", 1'b1, 32'h0000_8001, 1'b0);
        i_req0_valid = 1'b0;
        cyc();
        chk_out("drain", 1'b0, 32'h0000_8001, 1'b0);

        // mode 11 from EMPTY, then mode 10
        i_req0_valid = 1'b1;
        i_req0_imm   = 16'hFFFF;
        i_req0_mode  = 2'b11;
        i_ready      = 1'b0;
        #1;
        chk_rdy("empty_free", 1'b1, 1'b0);
        cyc();
        chk_out("zero", 1'b1, 32'h0, 1'b0);
        i_ready     = 1'b1;
        i_req0_imm  = 16'h8001;
        i_req0_mode = 2'b10;
        cyc();
        chk_out("upper", 1'b1, 32'h8001_0000, 1'b0);

        // reset mid-operation while FULL and stalled; last_served must return to 1
        i_ready      = 1'b0;
        i_req1_valid = 1'b1;
        i_rst        = 1'b1;
        #1;
        chk_rdy("midrst_in", 1'b0, 1'b0);
        cyc();
        chk_out("midrst", 1'b0, 32'h0, 1'b0);
        i_rst = 1'b0;
        #1;
        chk_rdy("midrst_tie", 1'b1, 1'b0);
        cyc();
        chk_out("post_rst", 1'b1, 32'h8001_0000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
